// File: rtl/tt_pkg.sv
// Shared types and sizing constants for the truth-table sweep checker.
// State names carry an ST_ prefix so they cannot collide with the SETTLE parameter.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

  localparam int TT_NUM_MINTERMS = 16;
  localparam int TT_IDX_W        = 4;
  localparam int TT_CNT_W        = 5;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle wait counter: cleared on entry to SETTLE, counts while enabled, and
// flags the last settle cycle so the FSM moves to SAMPLE after SETTLE cycles.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign expired = en && (count == 4'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives a 4-input function block through all 16 minterms, samples reference and
// minimized outputs after a settle delay, and reports tables, mismatches and pass.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                f_ref,
  input  logic                f_dut,
  output logic [TT_IDX_W-1:0] abcd,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [TT_CNT_W-1:0] mismatch_cnt,
  output logic [TT_IDX_W-1:0] first_bad,
  output logic                first_bad_valid,
  output logic [15:0]         ref_table,
  output logic [15:0]         dut_table
);

  tt_state_e           state;
  logic                load;
  logic                expired;
  logic                mis;
  logic                last;
  logic [TT_CNT_W-1:0] cnt_next;

  assign mis      = f_ref ^ f_dut;
  assign last     = (abcd == TT_IDX_W'(TT_NUM_MINTERMS - 1));
  assign load     = ((state == ST_IDLE) && start) || ((state == ST_SAMPLE) && !last);
  assign cnt_next = mismatch_cnt + TT_CNT_W'(mis);

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (state == ST_SETTLE),
    .expired (expired)
  );

  // abcd doubles as the minterm index; it is parked at 0 again when the FSM returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      abcd            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch_cnt    <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
      ref_table       <= '0;
      dut_table       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state           <= ST_SETTLE;
            abcd            <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            mismatch_cnt    <= '0;
            first_bad       <= '0;
            first_bad_valid <= 1'b0;
            ref_table       <= '0;
            dut_table       <= '0;
          end
        end
        ST_SETTLE: begin
          if (expired) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          ref_table[abcd] <= f_ref;
          dut_table[abcd] <= f_dut;
          if (mis) begin
            mismatch_cnt <= cnt_next;
            if (!first_bad_valid) begin
              first_bad       <= abcd;
              first_bad_valid <= 1'b1;
            end
          end
          // pass must account for the final minterm, so it uses the updated count.
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_next == '0);
          end else begin
            state <= ST_SETTLE;
            abcd  <= abcd + TT_IDX_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          abcd  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: two instances (SETTLE=1 and SETTLE=3)
// driven by a behavioural model of the 7-minterm function {3,7,8,9,12,13,15}.
module tb_tt_sweep_checker;

  localparam int S1 = 1;
  localparam int S3 = 3;

  typedef struct {
    logic [15:0] ref_t;
    logic [15:0] dut_t;
    logic [4:0]  cnt;
    logic [3:0]  fb;
    logic        fbv;
    logic        pass;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        eq1 = 1'b1, eq3 = 1'b1;
  logic [15:0] ref_fn = 16'hB388;

  logic        f_ref1, f_dut1, f_ref3, f_dut3;
  logic [3:0]  abcd1, abcd3, fb1, fb3;
  logic        busy1, busy3, done1, done3, pass1, pass3, fbv1, fbv3;
  logic [4:0]  cnt1, cnt3;
  logic [15:0] rt1, rt3, dt1, dt3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp1_q[$];
  exp_t exp3_q[$];

  assign f_ref1 = ref_fn[abcd1];
  assign f_dut1 = eq1 ? ref_fn[abcd1] : 1'b0;
  assign f_ref3 = ref_fn[abcd3];
  assign f_dut3 = eq3 ? ref_fn[abcd3] : 1'b0;

  tt_sweep_checker #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_ref(f_ref1), .f_dut(f_dut1),
    .abcd(abcd1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .first_bad(fb1), .first_bad_valid(fbv1), .ref_table(rt1), .dut_table(dt1)
  );

  tt_sweep_checker #(.SETTLE(S3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_ref(f_ref3), .f_dut(f_dut3),
    .abcd(abcd3), .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3),
    .first_bad(fb3), .first_bad_valid(fbv3), .ref_table(rt3), .dut_table(dt3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkSweep(input string tag, input exp_t e, input logic [15:0] rt,
                            input logic [15:0] dt, input logic [4:0] c, input logic [3:0] fb,
                            input logic fbv, input logic p, input logic b);
    checkOutput({tag, "_done_cycle"}, cyc, e.done_cyc);
    checkOutput({tag, "_ref_table"}, rt, e.ref_t);
    checkOutput({tag, "_dut_table"}, dt, e.dut_t);
    checkOutput({tag, "_mismatch_cnt"}, c, e.cnt);
    checkOutput({tag, "_first_bad"}, fb, e.fb);
    checkOutput({tag, "_first_bad_valid"}, fbv, e.fbv);
    checkOutput({tag, "_pass"}, p, e.pass);
    checkOutput({tag, "_busy_in_done"}, b, 1'b0);
  endtask

  task automatic checkIdleZero(input int inst);
    string t;
    t = (inst == 1) ? "rst1" : "rst3";
    if (inst == 1) begin
      checkOutput({t, "_abcd"}, abcd1, 0);
      checkOutput({t, "_flags"}, {busy1, done1, pass1, fbv1}, 0);
      checkOutput({t, "_cnt_fb"}, {cnt1, fb1}, 0);
      checkOutput({t, "_tables"}, {rt1, dt1}, 0);
    end else begin
      checkOutput({t, "_abcd"}, abcd3, 0);
      checkOutput({t, "_flags"}, {busy3, done3, pass3, fbv3}, 0);
      checkOutput({t, "_cnt_fb"}, {cnt3, fb3}, 0);
      checkOutput({t, "_tables"}, {rt3, dt3}, 0);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (exp1_q.size() == 0) checkOutput("dut1_unexpected_done", 1, 0);
      else checkSweep("dut1", exp1_q.pop_front(), rt1, dt1, cnt1, fb1, fbv1, pass1, busy1);
    end
  end

  always @(negedge clk) begin
    if (!rst && done3) begin
      if (exp3_q.size() == 0) checkOutput("dut3_unexpected_done", 1, 0);
      else checkSweep("dut3", exp3_q.pop_front(), rt3, dt3, cnt3, fb3, fbv3, pass3, busy3);
    end
  end

  // Called at a negedge: issues one sweep and optionally a stray start, a mid-sweep reset,
  // a clear-on-accept check or an abcd sequence check.
  task automatic applyStimulus(input int inst, input bit eq, input int restart_at,
                               input int reset_at, input bit chk_clear, input bit chk_seq);
    int   s;
    int   accept;
    int   n;
    int   seq_bad;
    bit   pulsed;
    bit   finished;
    exp_t e;
    logic [3:0] a;
    s        = (inst == 1) ? S1 : S3;
    seq_bad  = 0;
    pulsed   = 0;
    finished = 0;
    if (inst == 1) eq1 = eq; else eq3 = eq;
    accept     = cyc + 1;
    e.ref_t    = 16'hB388;
    e.dut_t    = eq ? 16'hB388 : 16'h0000;
    e.cnt      = eq ? 5'd0 : 5'd7;
    e.fb       = eq ? 4'd0 : 4'd3;
    e.fbv      = !eq;
    e.pass     = eq;
    e.done_cyc = accept + 16 * (s + 1);
    if (inst == 1) begin exp1_q.push_back(e); start1 = 1'b1; end
    else begin exp3_q.push_back(e); start3 = 1'b1; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      n = cyc - accept;
      a = (inst == 1) ? abcd1 : abcd3;
      if (k == 0 && chk_clear) begin
        if (inst == 1) begin
          checkOutput("clear_tables", {rt1, dt1}, 0);
          checkOutput("clear_cnt_fb", {cnt1, fb1, fbv1, pass1}, 0);
          checkOutput("clear_busy", busy1, 1);
        end else begin
          checkOutput("clear_tables", {rt3, dt3}, 0);
          checkOutput("clear_cnt_fb", {cnt3, fb3, fbv3, pass3}, 0);
          checkOutput("clear_busy", busy3, 1);
        end
      end
      if (chk_seq && n < 16 * (s + 1) && a != 4'(n / (s + 1))) seq_bad++;
      if (reset_at >= 0 && inst == 1 && abcd1 == 4'(reset_at)) begin
        @(posedge clk);
        #3 rst = 1'b1;
        #1 checkIdleZero(1);
        exp1_q.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (restart_at >= 0 && !pulsed && inst == 1 && abcd1 == 4'(restart_at)) begin
        start1 = 1'b1;
        pulsed = 1;
      end
      if ((inst == 1 && exp1_q.size() == 0) || (inst == 3 && exp3_q.size() == 0)) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      checkOutput("sweep_timeout", 1, 0);
      if (inst == 1) exp1_q.delete(); else exp3_q.delete();
    end
    if (chk_seq) checkOutput("abcd_seq_bad_cycles", seq_bad, 0);
  endtask

  initial begin
    $display("[TB] starting tt_sweep_checker bench");
    repeat (2) @(negedge clk);
    checkIdleZero(1);
    checkIdleZero(3);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b1, -1, -1, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, -1, -1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0,  6, -1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, -1, -1, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, -1,  9, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, -1, -1, 1'b0, 1'b1);
    applyStimulus(3, 1'b1, -1, -1, 1'b0, 1'b1);
    applyStimulus(3, 1'b0, -1, -1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
